// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Two-port round-robin arbiter and access sequencer for the shared 16-bit
// asynchronous SRAM. Port 0 (cpu) serves the LC-3 datapath, port 1 (ldr) the
// memory loader / debug block. One requester is granted at a time. The block
// then runs a fixed-length read or write with the address and strobes held
// stable. It finishes with a one-cycle ack and registered read data.
//
// Ports:
//   Clk, Reset                  clock, synchronous active-high reset
//   cpu_req/we/addr/wdata       cpu request (held until cpu_ack)
//   cpu_rdata, cpu_ack          registered read data, one-cycle completion
//   ldr_*                       same set for the loader port
//   Mem_ADDR                    registered SRAM address
//   Mem_Dout, Mem_Dout_en       write data and tristate enable (1 = drive)
//   Mem_Din                     SRAM read bus
//   Mem_CE_n/OE_n/WE_n          active-low SRAM strobes (registered)
//   Mem_UB_n, Mem_LB_n          byte lanes, always enabled
//
// Access timing (req sampled at edge k in IDLE):
//   cycles k+1 .. k+ACC_CYCLES  ACCESS, OE_n or WE_n low
//   cycle  k+ACC_CYCLES+1       DONE, strobes high, CE_n low, ack high
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int ACC_CYCLES = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  output logic [ADDR_W-1:0] Mem_ADDR,
  output logic [DATA_W-1:0] Mem_Dout,
  output logic              Mem_Dout_en,
  input  logic [DATA_W-1:0] Mem_Din,
  output logic              Mem_CE_n,
  output logic              Mem_OE_n,
  output logic              Mem_WE_n,
  output logic              Mem_UB_n,
  output logic              Mem_LB_n
);

  if (ACC_CYCLES < 1 || ACC_CYCLES > 15) begin : g_bad_acc
    $error("sram_arbiter: ACC_CYCLES must be in 1..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(ACC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       gnt_ldr;   // port owning the current access (1 = ldr)
  logic       last_ldr;  // port granted most recently (1 = ldr)
  logic       lat_we;    // direction of the current access

  // Arbitration: a lone requester wins; on a tie the port that did not win
  // last time is chosen, so a port that keeps requesting alternates.
  logic              pick_ldr;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    pick_ldr  = ldr_req && (!cpu_req || !last_ldr);
    sel_we    = pick_ldr ? ldr_we    : cpu_we;
    sel_addr  = pick_ldr ? ldr_addr  : cpu_addr;
    sel_wdata = pick_ldr ? ldr_wdata : cpu_wdata;
  end

  // Byte lanes are never masked: every access is a full 16-bit word.
  assign Mem_UB_n = 1'b0;
  assign Mem_LB_n = 1'b0;

  // Mem_ADDR and Mem_Dout double as the latched request address and write
  // data: they are loaded once at grant and held through DONE so the SRAM
  // sees address/data hold past the rising edge of WE_n.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      gnt_ldr     <= 1'b0;
      last_ldr    <= 1'b1;
      lat_we      <= 1'b0;
      cpu_ack     <= 1'b0;
      ldr_ack     <= 1'b0;
      cpu_rdata   <= '0;
      ldr_rdata   <= '0;
      Mem_ADDR    <= '0;
      Mem_Dout    <= '0;
      Mem_Dout_en <= 1'b0;
      Mem_CE_n    <= 1'b1;
      Mem_OE_n    <= 1'b1;
      Mem_WE_n    <= 1'b1;
    end else begin
      cpu_ack <= 1'b0;
      ldr_ack <= 1'b0;

      case (state)
        // IDLE: strobes parked high; grant and launch the access on the
        // same edge that samples the request.
        IDLE: begin
          Mem_CE_n    <= 1'b1;
          Mem_OE_n    <= 1'b1;
          Mem_WE_n    <= 1'b1;
          Mem_Dout_en <= 1'b0;
          if (cpu_req || ldr_req) begin
            gnt_ldr     <= pick_ldr;
            last_ldr    <= pick_ldr;
            lat_we      <= sel_we;
            Mem_ADDR    <= sel_addr;
            Mem_Dout    <= sel_wdata;
            Mem_CE_n    <= 1'b0;
            Mem_OE_n    <= sel_we;
            Mem_WE_n    <= !sel_we;
            Mem_Dout_en <= sel_we;
            cnt         <= CNT_LOAD;
            state       <= ACCESS;
          end
        end

        // ACCESS: strobe held low for ACC_CYCLES cycles. On the last edge
        // OE_n is still low, so Mem_Din is valid and captured here.
        ACCESS: begin
          if (cnt == 4'd0) begin
            Mem_OE_n <= 1'b1;
            Mem_WE_n <= 1'b1;
            if (!lat_we) begin
              if (gnt_ldr) begin
                ldr_rdata <= Mem_Din;
              end else begin
                cpu_rdata <= Mem_Din;
              end
            end
            if (gnt_ldr) begin
              ldr_ack <= 1'b1;
            end else begin
              cpu_ack <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        // DONE: one hold cycle with CE_n low, address and write data still
        // driven; release the bus on the way back to IDLE.
        DONE: begin
          Mem_CE_n    <= 1'b1;
          Mem_Dout_en <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Bench for sram_arbiter. Instance dut uses ACC_CYCLES=3 and instance dut1
// uses ACC_CYCLES=1. Each instance has a small behavioural SRAM indexed by the
// low address byte. Single transactions come from a vector table; contention,
// fairness, mid-access reset and the one-cycle build use directed sequences.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int AW   = 20;
  localparam int DW   = 16;
  localparam int ACC  = 3;
  localparam int ACC1 = 1;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  // ---------------- dut (ACC_CYCLES = 3) ----------------
  logic          cpu_req, cpu_we, ldr_req, ldr_we;
  logic [AW-1:0] cpu_addr, ldr_addr, Mem_ADDR;
  logic [DW-1:0] cpu_wdata, ldr_wdata, cpu_rdata, ldr_rdata, Mem_Dout, Mem_Din;
  logic          cpu_ack, ldr_ack, Mem_Dout_en, Mem_CE_n, Mem_OE_n, Mem_WE_n;
  logic          Mem_UB_n, Mem_LB_n;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYCLES(ACC)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .Mem_ADDR(Mem_ADDR), .Mem_Dout(Mem_Dout), .Mem_Dout_en(Mem_Dout_en), .Mem_Din(Mem_Din),
    .Mem_CE_n(Mem_CE_n), .Mem_OE_n(Mem_OE_n), .Mem_WE_n(Mem_WE_n),
    .Mem_UB_n(Mem_UB_n), .Mem_LB_n(Mem_LB_n)
  );

  // ---------------- dut1 (ACC_CYCLES = 1) ----------------
  logic          a1_cpu_req, a1_cpu_we, a1_ldr_req, a1_ldr_we;
  logic [AW-1:0] a1_cpu_addr, a1_ldr_addr, a1_Mem_ADDR;
  logic [DW-1:0] a1_cpu_wdata, a1_ldr_wdata, a1_cpu_rdata, a1_ldr_rdata, a1_Mem_Dout, a1_Mem_Din;
  logic          a1_cpu_ack, a1_ldr_ack, a1_Mem_Dout_en, a1_Mem_CE_n, a1_Mem_OE_n, a1_Mem_WE_n;
  logic          a1_Mem_UB_n, a1_Mem_LB_n;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYCLES(ACC1)) dut1 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(a1_cpu_req), .cpu_we(a1_cpu_we), .cpu_addr(a1_cpu_addr), .cpu_wdata(a1_cpu_wdata),
    .cpu_rdata(a1_cpu_rdata), .cpu_ack(a1_cpu_ack),
    .ldr_req(a1_ldr_req), .ldr_we(a1_ldr_we), .ldr_addr(a1_ldr_addr), .ldr_wdata(a1_ldr_wdata),
    .ldr_rdata(a1_ldr_rdata), .ldr_ack(a1_ldr_ack),
    .Mem_ADDR(a1_Mem_ADDR), .Mem_Dout(a1_Mem_Dout), .Mem_Dout_en(a1_Mem_Dout_en), .Mem_Din(a1_Mem_Din),
    .Mem_CE_n(a1_Mem_CE_n), .Mem_OE_n(a1_Mem_OE_n), .Mem_WE_n(a1_Mem_WE_n),
    .Mem_UB_n(a1_Mem_UB_n), .Mem_LB_n(a1_Mem_LB_n)
  );

  // ---------------- SRAM models ----------------
  logic [DW-1:0] mem  [0:255];
  logic [DW-1:0] mem1 [0:255];
  logic          pre_en, pre1_en;
  logic [7:0]    pre_a;
  logic [DW-1:0] pre_d;

  always @(posedge Clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (!Mem_CE_n && !Mem_WE_n && Mem_Dout_en) mem[Mem_ADDR[7:0]] <= Mem_Dout;
  end
  always @(posedge Clk) begin
    if (pre1_en) mem1[pre_a] <= pre_d;
  end

  // Read bus shows a marker value whenever the SRAM is not output-enabled.
  assign Mem_Din    = (!Mem_CE_n && !Mem_OE_n) ? mem[Mem_ADDR[7:0]] : 16'hDEAD;
  assign a1_Mem_Din = (!a1_Mem_CE_n && !a1_Mem_OE_n) ? mem1[a1_Mem_ADDR[7:0]] : 16'hDEAD;

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_cpu_rd, exp_ldr_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit            port;   // 0 = cpu, 1 = ldr
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rexp;   // expected read data (reads only)
  } vec_t;

  vec_t vecs [8];

  task automatic preload(input bit which, input logic [7:0] a, input logic [DW-1:0] d);
    @(negedge Clk);
    pre_a = a;
    pre_d = d;
    if (which) pre1_en = 1'b1; else pre_en = 1'b1;
    @(negedge Clk);
    pre_en  = 1'b0;
    pre1_en = 1'b0;
  endtask

  // Runs one transaction on dut starting at a negedge with the FSM idle.
  // Strobe vector packs {CE_n, OE_n, WE_n, Dout_en, cpu_ack, ldr_ack}.
  task automatic run_txn(input vec_t v, input int idx);
    logic [5:0] exp_s;
    if (v.port) begin
      ldr_req = 1'b1; ldr_we = v.we; ldr_addr = v.addr; ldr_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    @(posedge Clk);
    for (int c = 0; c <= ACC; c++) begin
      @(negedge Clk);
      if (c < ACC) begin
        exp_s = {1'b0, v.we, !v.we, v.we, 2'b00};
      end else begin
        exp_s = {1'b0, 1'b1, 1'b1, v.we, !v.port, v.port};
        if (!v.we) begin
          if (v.port) exp_ldr_rd = v.rexp; else exp_cpu_rd = v.rexp;
        end
        check($sformatf("v%0d_cpu_rdata", idx), 32'(cpu_rdata), 32'(exp_cpu_rd));
        check($sformatf("v%0d_ldr_rdata", idx), 32'(ldr_rdata), 32'(exp_ldr_rd));
      end
      check($sformatf("v%0d_c%0d_strobes", idx, c),
            32'({Mem_CE_n, Mem_OE_n, Mem_WE_n, Mem_Dout_en, cpu_ack, ldr_ack}), 32'(exp_s));
      check($sformatf("v%0d_c%0d_addr", idx, c), 32'(Mem_ADDR), 32'(v.addr));
      if (v.we) check($sformatf("v%0d_c%0d_dout", idx, c), 32'(Mem_Dout), 32'(v.wdata));
      if (c == 0) begin
        // Request inputs wander mid-access; the latched values must hold.
        if (v.port) begin
          ldr_we = !v.we; ldr_addr = ~v.addr; ldr_wdata = ~v.wdata;
        end else begin
          cpu_we = !v.we; cpu_addr = ~v.addr; cpu_wdata = ~v.wdata;
        end
      end
    end
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    @(negedge Clk);
    check($sformatf("v%0d_idle_strobes", idx),
          32'({Mem_CE_n, Mem_OE_n, Mem_WE_n, Mem_Dout_en, cpu_ack, ldr_ack}), 32'(6'b111000));
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    exp_cpu_rd = '0;
    exp_ldr_rd = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    a1_cpu_req = 1'b0; a1_cpu_we = 1'b0; a1_cpu_addr = '0; a1_cpu_wdata = '0;
    a1_ldr_req = 1'b0; a1_ldr_we = 1'b0; a1_ldr_addr = '0; a1_ldr_wdata = '0;
    pre_en = 1'b0; pre1_en = 1'b0; pre_a = '0; pre_d = '0;
    exp_cpu_rd = '0; exp_ldr_rd = '0;

    vecs[0] = '{1'b0, 1'b0, 20'h00010, 16'h0000, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b1, 20'h0003F, 16'h1234, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 20'h0003F, 16'h0000, 16'h1234};
    vecs[3] = '{1'b0, 1'b1, 20'h00120, 16'hA5A5, 16'h0000};
    vecs[4] = '{1'b0, 1'b0, 20'h00120, 16'h0000, 16'hA5A5};
    vecs[5] = '{1'b0, 1'b0, 20'hFFFFF, 16'h0000, 16'h0F0F};
    vecs[6] = '{1'b1, 1'b1, 20'hFFFFF, 16'hFFFF, 16'h0000};
    vecs[7] = '{1'b1, 1'b0, 20'hFFFFF, 16'h0000, 16'hFFFF};

    // Preload while both instances are held in reset.
    preload(1'b0, 8'h10, 16'hBEEF);
    preload(1'b0, 8'hFF, 16'h0F0F);
    preload(1'b1, 8'h5A, 16'h5A5A);
    preload(1'b1, 8'h5B, 16'hA5A5);

    // Reset state.
    check("rst_strobes", 32'({Mem_CE_n, Mem_OE_n, Mem_WE_n, Mem_Dout_en, cpu_ack, ldr_ack}), 32'(6'b111000));
    check("rst_addr", 32'(Mem_ADDR), 32'h0);
    check("rst_dout", 32'(Mem_Dout), 32'h0);
    check("rst_rdata", 32'({cpu_rdata, ldr_rdata}), 32'h0);
    check("rst_ublb", 32'({Mem_UB_n, Mem_LB_n}), 32'h0);
    check("rst1_strobes", 32'({a1_Mem_CE_n, a1_Mem_OE_n, a1_Mem_WE_n, a1_Mem_Dout_en, a1_cpu_ack, a1_ldr_ack}),
          32'(6'b111000));
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    // Single transactions from the table.
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i], i);
      if (i == 1) check("mem_3f_after_write", 32'(mem[8'h3F]), 32'h1234);
    end
    check("mem_ff_after_write", 32'(mem[8'hFF]), 32'hFFFF);

    // Contention right after reset: cpu first, ldr at the next IDLE.
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00010;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 20'h0003F;
    @(posedge Clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      check($sformatf("cont_c%0d_acks", c), 32'({cpu_ack, ldr_ack}), 32'({c == 3, c == 8}));
      if (cpu_ack) cpu_req = 1'b0;
      if (ldr_ack) ldr_req = 1'b0;
    end
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    check("cont_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
    check("cont_ldr_rdata", 32'(ldr_rdata), 32'h1234);

    // Fairness: both ports request continuously; grants alternate.
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00010;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 20'h0003F;
    @(posedge Clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      check($sformatf("fair_c%0d_acks", c), 32'({cpu_ack, ldr_ack}),
            32'({(c % 10) == 3, (c % 10) == 8}));
    end
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    @(negedge Clk);
    check("fair_idle_ce", 32'(Mem_CE_n), 32'h1);

    // Reset in the second ACCESS cycle of a cpu write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00050; cpu_wdata = 16'h7777;
    @(posedge Clk);
    @(negedge Clk);
    check("rstacc_c0_we", 32'(Mem_WE_n), 32'h0);
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    cpu_req = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check("rstacc_strobes", 32'({Mem_CE_n, Mem_OE_n, Mem_WE_n, Mem_Dout_en, cpu_ack, ldr_ack}), 32'(6'b111000));
    check("rstacc_rdata", 32'({cpu_rdata, ldr_rdata}), 32'h0);
    Reset = 1'b0;
    exp_cpu_rd = '0;
    exp_ldr_rd = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      check($sformatf("rstacc_noack_c%0d", c), 32'({cpu_ack, ldr_ack, Mem_CE_n}), 32'(3'b001));
    end
    run_txn(vecs[0], 8);

    // One-cycle build: back-to-back cpu reads spaced three cycles.
    a1_cpu_req = 1'b1; a1_cpu_we = 1'b0; a1_cpu_addr = 20'h0005A;
    @(posedge Clk);
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      check($sformatf("acc1_c%0d_oe_ack", c), 32'({a1_Mem_OE_n, a1_cpu_ack}),
            32'({!(c == 0 || c == 3), (c == 1 || c == 4)}));
      if (c == 1) begin
        check("acc1_rdata_0", 32'(a1_cpu_rdata), 32'h5A5A);
        a1_cpu_addr = 20'h0005B;
      end
      if (c == 4) begin
        check("acc1_rdata_1", 32'(a1_cpu_rdata), 32'hA5A5);
        a1_cpu_req = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
